// File: rtl/ray_pkg.sv
// rtl/ray_pkg.sv - shared field layout, constants and FSM states for the sphere unit
package ray_pkg;

    localparam logic [9:0] T_MISS = 10'd1023;
    localparam int         ITER   = 24;

    localparam int POS_W    = 10;
    localparam int DEPTH_W  = 8;
    localparam int DIR_XY_W = 11;
    localparam int DIR_Z_W  = 9;
    localparam int RAD_W    = 8;

    localparam int INIT_OX_LSB   = 18;
    localparam int INIT_OY_LSB   = 8;
    localparam int INIT_OZ_LSB   = 0;
    localparam int DIR_DX_LSB    = 20;
    localparam int DIR_DY_LSB    = 9;
    localparam int DIR_DZ_LSB    = 0;
    localparam int OBJ_COLOR_LSB = 36;
    localparam int OBJ_R_LSB     = 28;
    localparam int OBJ_CX_LSB    = 18;
    localparam int OBJ_CY_LSB    = 8;
    localparam int OBJ_CZ_LSB    = 0;

    typedef enum logic [2:0] {LOAD, PROD, DISC, SQRT, DIV, OUT} ray_state_t;

    function automatic logic [19:0] sat20(input logic [48:0] value);
        return (value > 49'hFFFFF) ? 20'hFFFFF : value[19:0];
    endfunction

endpackage

// File: rtl/ray_isqrt_seq.sv
// rtl/ray_isqrt_seq.sv - restoring bit-serial square root of a 48-bit radicand, ITER cycles
module ray_isqrt_seq
    import ray_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [47:0] radicand,
    output logic        done,
    output logic [23:0] root
);

    logic [47:0] rad_q;
    logic [25:0] rem_q;
    logic [4:0]  cnt;
    logic        busy;

    logic [47:0] src_rad;
    logic [25:0] src_rem;
    logic [23:0] src_root;
    logic [27:0] rem_sh;
    logic [27:0] trial;
    logic        ge;

    // The start cycle already performs the first iteration so the root is ready after ITER edges.
    assign src_rad  = start ? radicand : rad_q;
    assign src_rem  = start ? 26'd0 : rem_q;
    assign src_root = start ? 24'd0 : root;
    assign rem_sh   = {src_rem, src_rad[47:46]};
    assign trial    = {2'b00, src_root, 2'b01};
    assign ge       = (rem_sh >= trial);

    always_ff @(posedge clk) begin
        if (rst) begin
            rad_q <= '0;
            rem_q <= '0;
            root  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start || busy) begin
                rad_q <= {src_rad[45:0], 2'b00};
                rem_q <= ge ? 26'(rem_sh - trial) : rem_sh[25:0];
                root  <= {src_root[22:0], ge};
                if (start) begin
                    cnt  <= 5'd1;
                    busy <= 1'b1;
                end else begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(ITER - 1)) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ray_tracer_sphere_unit.sv
// rtl/ray_tracer_sphere_unit.sv - free-running fixed-point ray/sphere intersection engine
module ray_tracer_sphere_unit
    import ray_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [27:0] init,
    input  logic [30:0] dir,
    input  logic [47:0] object_in,
    output logic [9:0]  t_out,
    output logic [19:0] d_mold_show,
    output logic [19:0] delta_show,
    output logic [19:0] div_res_show,
    output logic [19:0] final_show
);

    ray_state_t state;

    logic [27:0]              init_q;
    logic [30:0]              dir_q;
    logic [OBJ_COLOR_LSB-1:0] obj_q;

    logic signed [23:0] b_q, c_q;
    logic [22:0]        m_q;
    logic signed [48:0] delta_q;
    logic               miss_q;
    logic [4:0]         div_cnt;
    logic [23:0]        div_rem;
    logic [23:0]        quo_q;

    // Colour travels with the sphere for the shader; intersection ignores it.
    logic unused_color;
    assign unused_color = ^object_in[47:OBJ_COLOR_LSB];

    logic [POS_W-1:0]          ox, oy, cx, cy;
    logic [DEPTH_W-1:0]        oz, cz;
    logic [RAD_W-1:0]          r;
    logic signed [DIR_XY_W-1:0] dx, dy, lx, ly, lz;
    logic signed [DIR_Z_W-1:0]  dz;

    assign ox = init_q[INIT_OX_LSB +: POS_W];
    assign oy = init_q[INIT_OY_LSB +: POS_W];
    assign oz = init_q[INIT_OZ_LSB +: DEPTH_W];
    assign dx = dir_q[DIR_DX_LSB +: DIR_XY_W];
    assign dy = dir_q[DIR_DY_LSB +: DIR_XY_W];
    assign dz = dir_q[DIR_DZ_LSB +: DIR_Z_W];
    assign r  = obj_q[OBJ_R_LSB +: RAD_W];
    assign cx = obj_q[OBJ_CX_LSB +: POS_W];
    assign cy = obj_q[OBJ_CY_LSB +: POS_W];
    assign cz = obj_q[OBJ_CZ_LSB +: DEPTH_W];

    assign lx = {1'b0, cx} - {1'b0, ox};
    assign ly = {1'b0, cy} - {1'b0, oy};
    assign lz = {3'b000, cz} - {3'b000, oz};

    logic signed [23:0] b_next, c_next, r_sq;
    logic signed [22:0] m_next;
    logic signed [48:0] delta_next;
    logic               miss_disc;
    logic               sqrt_start, sqrt_done;
    logic [23:0]        root;

    assign b_next = 24'(lx) * 24'(dx) + 24'(ly) * 24'(dy) + 24'(lz) * 24'(dz);
    assign m_next = 23'(dx) * 23'(dx) + 23'(dy) * 23'(dy) + 23'(dz) * 23'(dz);
    assign r_sq   = {16'd0, r} * {16'd0, r};
    assign c_next = 24'(lx) * 24'(lx) + 24'(ly) * 24'(ly) + 24'(lz) * 24'(lz) - r_sq;

    assign delta_next = 49'(b_q) * 49'(b_q) - 49'($signed({1'b0, m_q})) * 49'(c_q);
    assign miss_disc  = delta_next[48] || (m_q == 23'd0);
    assign sqrt_start = (state == DISC) && !miss_disc;

    ray_isqrt_seq u_isqrt (
        .clk      (clk),
        .rst      (rst),
        .start    (sqrt_start),
        .radicand (delta_next[47:0]),
        .done     (sqrt_done),
        .root     (root)
    );

    // Near root first; fall back to the far root when the origin sits inside the sphere.
    logic signed [25:0] b_minus_s, b_plus_s, n_sel;
    logic [24:0]        n_mag;
    logic               miss_div, hit;

    assign b_minus_s = 26'(b_q) - 26'($signed({1'b0, root}));
    assign b_plus_s  = 26'(b_q) + 26'($signed({1'b0, root}));
    assign n_sel     = b_minus_s[25] ? b_plus_s : b_minus_s;
    assign n_mag     = n_sel[24:0];
    assign miss_div  = b_plus_s[25];
    assign hit       = !miss_q && !miss_div;

    logic [4:0]  bit_idx;
    logic [23:0] rem_base;
    logic [24:0] rem_sh;
    logic        div_ge;

    assign bit_idx  = 5'(ITER - 1) - div_cnt;
    assign rem_base = (div_cnt == 5'd0) ? {23'd0, n_mag[24]} : div_rem;
    assign rem_sh   = {rem_base, n_mag[bit_idx]};
    assign div_ge   = (rem_sh >= {2'b00, m_q});

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= LOAD;
            init_q       <= '0;
            dir_q        <= '0;
            obj_q        <= '0;
            b_q          <= '0;
            c_q          <= '0;
            m_q          <= '0;
            delta_q      <= '0;
            miss_q       <= 1'b0;
            div_cnt      <= '0;
            div_rem      <= '0;
            quo_q        <= '0;
            t_out        <= T_MISS;
            d_mold_show  <= '0;
            delta_show   <= '0;
            div_res_show <= '0;
            final_show   <= '0;
        end else begin
            case (state)
                LOAD: begin
                    init_q <= init;
                    dir_q  <= dir;
                    obj_q  <= object_in[OBJ_COLOR_LSB-1:0];
                    state  <= PROD;
                end
                PROD: begin
                    b_q   <= b_next;
                    m_q   <= m_next;
                    c_q   <= c_next;
                    state <= DISC;
                end
                DISC: begin
                    delta_q <= delta_next;
                    miss_q  <= miss_disc;
                    div_cnt <= '0;
                    state   <= miss_disc ? OUT : SQRT;
                end
                SQRT: begin
                    if (sqrt_done) state <= DIV;
                end
                DIV: begin
                    div_rem <= div_ge ? 24'(rem_sh - {2'b00, m_q}) : rem_sh[23:0];
                    quo_q   <= (div_cnt == 5'd0) ? {23'd0, div_ge} : {quo_q[22:0], div_ge};
                    div_cnt <= div_cnt + 5'd1;
                    if (div_cnt == 5'(ITER - 1)) state <= OUT;
                end
                OUT: begin
                    t_out        <= !hit ? T_MISS : (quo_q > 24'd1022) ? 10'd1022 : quo_q[9:0];
                    d_mold_show  <= sat20(49'(m_q));
                    delta_show   <= delta_q[48] ? 20'd0 : sat20(49'(delta_q));
                    div_res_show <= hit ? sat20(49'(quo_q)) : 20'd0;
                    final_show   <= hit ? sat20(49'(n_sel)) : 20'd0;
                    state        <= LOAD;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_ray_tracer_sphere_unit.sv
// tb/tb_ray_tracer_sphere_unit.sv - self-checking bench with an arithmetic reference model
module tb_ray_tracer_sphere_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [27:0] init;
    logic [30:0] dir;
    logic [47:0] object_in;
    logic [9:0]  t_out;
    logic [19:0] d_mold_show, delta_show, div_res_show, final_show;

    int tests = 0;
    int fails = 0;
    logic [9:0] prev_t;

    ray_tracer_sphere_unit dut (
        .clk          (clk),
        .rst          (rst),
        .init         (init),
        .dir          (dir),
        .object_in    (object_in),
        .t_out        (t_out),
        .d_mold_show  (d_mold_show),
        .delta_show   (delta_show),
        .div_res_show (div_res_show),
        .final_show   (final_show)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        return (v > 64'sd1048575) ? 64'sd1048575 : v;
    endfunction

    function automatic longint isqrt(input longint v);
        longint s;
        s = longint'($floor($sqrt(real'(v))));
        while (s * s > v) s--;
        while ((s + 1) * (s + 1) <= v) s++;
        return s;
    endfunction

    task automatic model(input logic [27:0] i_v, input logic [30:0] d_v, input logic [47:0] o_v,
                         output longint et, output longint edm, output longint edl,
                         output longint edv, output longint efin, output int lat, output bit hit);
        longint ox, oy, oz, dx, dy, dz, r, cx, cy, cz, lx, ly, lz, b, m, c, delta, s, n, q;
        ox = i_v[27:18]; oy = i_v[17:8]; oz = i_v[7:0];
        dx = longint'($signed(d_v[30:20]));
        dy = longint'($signed(d_v[19:9]));
        dz = longint'($signed(d_v[8:0]));
        r  = o_v[35:28]; cx = o_v[27:18]; cy = o_v[17:8]; cz = o_v[7:0];
        lx = cx - ox; ly = cy - oy; lz = cz - oz;
        b = lx * dx + ly * dy + lz * dz;
        m = dx * dx + dy * dy + dz * dz;
        c = lx * lx + ly * ly + lz * lz - r * r;
        delta = b * b - m * c;
        edm = sat(m);
        edl = (delta < 0) ? 0 : sat(delta);
        et = 1023; edv = 0; efin = 0; hit = 0;
        if (delta < 0 || m == 0) begin
            lat = 4;
        end else begin
            lat = 52;
            s = isqrt(delta);
            n = (b - s >= 0) ? b - s : b + s;
            if (n >= 0) begin
                q    = n / m;
                hit  = 1;
                et   = (q > 1022) ? 1022 : q;
                edv  = sat(q);
                efin = sat(n);
            end
        end
    endtask

    // Entered at a negedge whose following posedge is a LOAD edge; returns at the negedge after OUT.
    task automatic run_case(input string tag, input logic [27:0] i_v, input logic [30:0] d_v,
                            input logic [47:0] o_v, input bit chg, input logic [30:0] d_new);
        longint et, edm, edl, edv, efin;
        int lat;
        bit hit;
        init = i_v; dir = d_v; object_in = o_v;
        model(i_v, d_v, o_v, et, edm, edl, edv, efin, lat, hit);
        for (int k = 0; k < lat - 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (chg && k == 5) dir = d_new;
        end
        check({tag, "_t_before"}, 64'(t_out), 64'(prev_t));
        @(posedge clk);
        @(negedge clk);
        check({tag, "_t_out"}, 64'(t_out), 64'(et));
        check({tag, "_d_mold"}, 64'(d_mold_show), 64'(edm));
        check({tag, "_delta"}, 64'(delta_show), 64'(edl));
        check({tag, "_final"}, 64'(final_show), 64'(efin));
        if (hit) check({tag, "_div_res"}, 64'(div_res_show), 64'(edv));
        prev_t = 10'(et);
    endtask

    logic [47:0] sphere;
    logic [30:0] dir_a, dir_steep, dir_miss;
    int ox, oy, oz, rdx, rdy, rdz;

    initial begin
        sphere    = {12'd0, 8'd16, 10'd0, 10'd32, 8'd0};
        dir_a     = {11'd1, 11'd7, 9'd1};
        dir_steep = {11'd1, 11'd32, 9'd1};
        dir_miss  = 31'b11111101000_00000000011_000011100;

        rst = 1'b1; init = '0; dir = '0; object_in = '0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_t_out", 64'(t_out), 64'd1023);
        check("rst_d_mold", 64'(d_mold_show), 64'd0);
        check("rst_delta", 64'(delta_show), 64'd0);
        check("rst_div_res", 64'(div_res_show), 64'd0);
        check("rst_final", 64'(final_show), 64'd0);
        rst = 1'b0;
        prev_t = 10'd1023;

        run_case("hit_out", 28'd0, dir_a, sphere, 1'b0, '0);
        check("hit_out_const_t", 64'(t_out), 64'd2);
        check("hit_out_const_delta", 64'(delta_show), 64'd11008);
        check("hit_out_const_final", 64'(final_show), 64'd120);
        check("hit_out_const_dm", 64'(d_mold_show), 64'd51);

        run_case("steep", 28'd0, dir_steep, sphere, 1'b0, '0);
        check("steep_const_delta", 64'(delta_show), 64'd260608);
        check("steep_const_final", 64'(final_show), 64'd514);

        run_case("miss", 28'd0, dir_miss, sphere, 1'b0, '0);
        check("miss_const_t", 64'(t_out), 64'd1023);

        run_case("chg_sqrt", 28'd0, dir_a, sphere, 1'b1, dir_steep);
        run_case("chg_next", 28'd0, dir_steep, sphere, 1'b0, '0);

        run_case("dir_zero", 28'd0, 31'd0, sphere, 1'b0, '0);
        run_case("inside", {10'd0, 10'd32, 8'd0}, {11'd0, 11'd1, 9'd0}, sphere, 1'b0, '0);
        check("inside_const_t", 64'(t_out), 64'd16);
        check("inside_const_final", 64'(final_show), 64'd16);
        run_case("behind", 28'd0, {11'h7FF, 11'd0, 9'd0} ^ {11'h7FF, 11'h7FF, 9'd0}, sphere, 1'b0, '0);

        run_case("pre_rst", 28'd0, dir_a, sphere, 1'b0, '0);
        repeat (35) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_div_t_out", 64'(t_out), 64'd1023);
        check("rst_div_d_mold", 64'(d_mold_show), 64'd0);
        check("rst_div_final", 64'(final_show), 64'd0);
        check("rst_div_div_res", 64'(div_res_show), 64'd0);
        rst = 1'b0;
        prev_t = 10'd1023;
        run_case("post_rst", 28'd0, dir_miss, sphere, 1'b0, '0);

        for (int k = 0; k < 14; k++) begin
            if (k % 2 == 0) begin
                run_case("rand_full", 28'($urandom), 31'($urandom), 48'({$urandom, $urandom}), 1'b0, '0);
            end else begin
                ox  = int'($urandom_range(0, 900));
                oy  = int'($urandom_range(0, 900));
                oz  = int'($urandom_range(0, 200));
                rdx = int'($urandom_range(0, 64)) - 32;
                rdy = int'($urandom_range(0, 64)) - 32;
                rdz = int'($urandom_range(0, 64)) - 32;
                run_case("rand_near", {10'(ox), 10'(oy), 8'(oz)},
                         {11'(rdx), 11'(rdy), 9'(rdz)},
                         {12'($urandom), 8'($urandom_range(1, 255)),
                          10'(ox + int'($urandom_range(0, 100))),
                          10'(oy + int'($urandom_range(0, 100))),
                          8'(oz + int'($urandom_range(0, 50)))}, 1'b0, '0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
